arm_hazard_scoreboard: RTL

Parametrised hazard-detection and forwarding-control unit for the ARM pipeline, replacing the fixed two-stage, stall-only hazard check. It keeps a shift-register scoreboard of in-flight writers behind the ID stage and raises a stall on unresolved read-after-write hazards. It also produces per-source forwarding selects for the EXE operand muxes and keeps a saturating stall-cycle counter. It sits beside the ID stage; its `hazard` output drives the IF freeze and the ID bubble insertion.

---
 rtl/arm_pipe_pkg.sv | 32 +++
 rtl/arm_hazard_match.sv | 47 ++++
 rtl/arm_hazard_scoreboard.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// ---------------------------------------------------------------------------
// arm_pipe_pkg
// Shared definitions for the ARM pipeline hazard logic:
//   - default register-index width, tracked-stage count and load stage
//   - FWD_REGFILE: forwarding-select code for "take operand from register file"
//   - sb_entry_t: one scoreboard entry {valid, wb_en, mem_read, dest}
//   - entry_writes(): does a scoreboard entry write a given register
// The entry's dest field is REG_BITS_MAX wide so that one struct type serves
// every legal REG_BITS; narrower indices are zero-extended by the users.
// ---------------------------------------------------------------------------
package arm_pipe_pkg;

  localparam int REG_BITS_DEF   = 4;
  localparam int STAGES_DEF     = 3;
  localparam int LOAD_STAGE_DEF = 2;
  localparam int REG_BITS_MAX   = 8;
  localparam int FWD_REGFILE    = 0;

  typedef struct packed {
    logic                    valid;
    logic                    wb_en;
    logic                    mem_read;
    logic [REG_BITS_MAX-1:0] dest;
  } sb_entry_t;

  // True when the entry holds a live instruction that writes register r.
  function automatic logic entry_writes(input sb_entry_t e,
                                        input logic [REG_BITS_MAX-1:0] r);
    return e.valid & e.wb_en & (e.dest == r);
  endfunction

endpackage

// File: rtl/arm_hazard_match.sv
// ---------------------------------------------------------------------------
// arm_hazard_match
// Youngest-match priority encoder for one source operand against the
// in-flight scoreboard. Entry 0 is the youngest (EXE).
// Ports:
//   entries      in  : scoreboard contents, entries[0] youngest
//   src          in  : source register index (zero-extended)
//   enable       in  : source is real and ID holds an instruction
//   hit          out : some entry writes src
//   hit_sel      out : index+1 of the youngest writing entry, 0 when none
//   hit_load_use out : youngest writer is a load whose data is not yet
//                      forwardable (index < LOAD_STAGE)
// ---------------------------------------------------------------------------
module arm_hazard_match
  import arm_pipe_pkg::*;
#(
  parameter int STAGES     = STAGES_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int SEL_W      = $clog2(STAGES_DEF + 1)
) (
  input  sb_entry_t               entries [STAGES],
  input  logic [REG_BITS_MAX-1:0] src,
  input  logic                    enable,
  output logic                    hit,
  output logic [SEL_W-1:0]        hit_sel,
  output logic                    hit_load_use
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit          = 1'b0;
    hit_sel      = '0;
    hit_load_use = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (enable && entry_writes(entries[i], src)) begin
        hit          = 1'b1;
        hit_sel      = SEL_W'(i + 1);
        hit_load_use = entries[i].mem_read && (i < LOAD_STAGE);
      end else begin
        hit          = hit;
        hit_sel      = hit_sel;
        hit_load_use = hit_load_use;
      end
    end
  end

endmodule

// File: rtl/arm_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// arm_hazard_scoreboard
// Hazard detection and forwarding control beside the ID stage. A shift
// register of in-flight writers (entry 0 = EXE, 1 = MEM, 2 = WB) is compared
// against the ID sources; unresolved read-after-write hazards raise `hazard`,
// which freezes IF and inserts a bubble into EXE.
//
// Build option ARM_HAZARD_FORWARDING_EN:
//   defined   : stall only on load-use (load not yet at LOAD_STAGE), and
//               drive fwd_sel1/fwd_sel2 with the youngest matching entry.
//   undefined : stall on any RAW match, fwd_sel1/fwd_sel2 tied to 0.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   id_valid, id_wb_en, id_mem_read, id_dest : ID instruction description
//   src1, src2, two_src : ID source registers; src2 used only when two_src
//   flush             : branch taken in EXE, ID instruction discarded
//   cnt_clr           : synchronous clear of stall_count
//   hazard            : stall request (combinational)
//   fwd_sel1/fwd_sel2 : operand source, 0 = regfile, k = entry k-1
//   stall_count       : saturating count of cycles with hazard high
// REG_BITS must not exceed arm_pipe_pkg::REG_BITS_MAX.
// ---------------------------------------------------------------------------
module arm_hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int REG_BITS   = REG_BITS_DEF,
  parameter int STAGES     = STAGES_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic                         id_wb_en,
  input  logic                         id_mem_read,
  input  logic [REG_BITS-1:0]          id_dest,
  input  logic [REG_BITS-1:0]          src1,
  input  logic [REG_BITS-1:0]          src2,
  input  logic                         two_src,
  input  logic                         flush,
  input  logic                         cnt_clr,
  output logic                         hazard,
  output logic [$clog2(STAGES+1)-1:0]  fwd_sel1,
  output logic [$clog2(STAGES+1)-1:0]  fwd_sel2,
  output logic [CNT_W-1:0]             stall_count
);

  localparam int SEL_W = $clog2(STAGES + 1);

  sb_entry_t               sb_r [STAGES];
  sb_entry_t               sb_in_s;
  logic [REG_BITS_MAX-1:0] dest_ext_s;
  logic [REG_BITS_MAX-1:0] src1_ext_s;
  logic [REG_BITS_MAX-1:0] src2_ext_s;
  logic                    m1_hit_s;
  logic                    m2_hit_s;
  logic [SEL_W-1:0]        m1_sel_s;
  logic [SEL_W-1:0]        m2_sel_s;
  logic                    m1_load_s;
  logic                    m2_load_s;
  logic                    raw_hazard_s;
  logic                    hazard_s;
  logic [SEL_W-1:0]        sel1_s;
  logic [SEL_W-1:0]        sel2_s;
  logic                    unused_match_s;
  logic [CNT_W-1:0]        cnt_r;

  // Zero-extend register indices to the scoreboard's dest width.
  always_comb begin
    dest_ext_s                 = '0;
    src1_ext_s                 = '0;
    src2_ext_s                 = '0;
    dest_ext_s[REG_BITS-1:0]   = id_dest;
    src1_ext_s[REG_BITS-1:0]   = src1;
    src2_ext_s[REG_BITS-1:0]   = src2;
  end

  arm_hazard_match #(
    .STAGES     (STAGES),
    .LOAD_STAGE (LOAD_STAGE),
    .SEL_W      (SEL_W)
  ) u_match1 (
    .entries      (sb_r),
    .src          (src1_ext_s),
    .enable       (id_valid),
    .hit          (m1_hit_s),
    .hit_sel      (m1_sel_s),
    .hit_load_use (m1_load_s)
  );

  arm_hazard_match #(
    .STAGES     (STAGES),
    .LOAD_STAGE (LOAD_STAGE),
    .SEL_W      (SEL_W)
  ) u_match2 (
    .entries      (sb_r),
    .src          (src2_ext_s),
    .enable       (id_valid & two_src),
    .hit          (m2_hit_s),
    .hit_sel      (m2_sel_s),
    .hit_load_use (m2_load_s)
  );

`ifdef ARM_HAZARD_FORWARDING_EN
  // Forwarding build: only an unforwardable load stalls; a source stuck
  // behind such a load reads the register file until the stall clears.
  always_comb begin
    raw_hazard_s   = m1_load_s | m2_load_s;
    sel1_s         = m1_load_s ? SEL_W'(FWD_REGFILE) : m1_sel_s;
    sel2_s         = m2_load_s ? SEL_W'(FWD_REGFILE) : m2_sel_s;
    unused_match_s = m1_hit_s ^ m2_hit_s;
  end
`else
  // Stall-only build: any RAW match stalls until the writer leaves WB.
  always_comb begin
    raw_hazard_s   = m1_hit_s | m2_hit_s;
    sel1_s         = SEL_W'(FWD_REGFILE);
    sel2_s         = SEL_W'(FWD_REGFILE);
    unused_match_s = ^{m1_sel_s, m2_sel_s, m1_load_s, m2_load_s};
  end
`endif

  // Flush wins over any hazard: the discarded instruction never stalls.
  always_comb begin
    if (flush) begin
      hazard_s = 1'b0;
    end else begin
      hazard_s = raw_hazard_s;
    end
  end

  // Next entry 0: the ID instruction if it issues, otherwise a bubble.
  always_comb begin
    sb_in_s = '0;
    if (id_valid && !hazard_s && !flush) begin
      sb_in_s.valid    = 1'b1;
      sb_in_s.wb_en    = id_wb_en;
      sb_in_s.mem_read = id_mem_read;
      sb_in_s.dest     = dest_ext_s;
    end else begin
      sb_in_s = '0;
    end
  end

  // Scoreboard shift register, youngest at index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sb_r[i] <= '0;
      end
    end else begin
      sb_r[0] <= sb_in_s;
      for (int i = 1; i < STAGES; i++) begin
        sb_r[i] <= sb_r[i-1];
      end
    end
  end

  // Saturating stall-cycle counter; clear has priority over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else if (hazard_s && (cnt_r != '1)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hazard      = hazard_s;
  assign fwd_sel1    = sel1_s;
  assign fwd_sel2    = sel2_s;
  assign stall_count = cnt_r;

endmodule
